bus_rr_arbiter: RTL and testbench

//   Round-robin arbiter/sequencer for the shared packet bus between drvrs driver FIFOs.

---
 rtl/bus_rr_arbiter.sv | 161 ++++++++++++++++
 tb/tb_bus_rr_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_rr_arbiter.sv
// -----------------------------------------------------------------------------
// bus_rr_arbiter
//   Round-robin arbiter/sequencer for a shared packet bus between driver FIFOs.
//   Each transaction grants one pending source, pops one packet from its FIFO,
//   decodes the destination ID in the top 8 bits and pushes the packet into
//   the destination FIFO (unicast) or into every FIFO but the source
//   (broadcast). Self-addressed packets and unknown IDs are dropped.
//   A transaction takes three cycles: IDLE (arbitrate), POP, DELIVER.
//
// Ports
//   clk      in   rising-edge clock
//   reset    in   asynchronous, active-low reset
//   pndng    in   [drvrs]          FIFO i non-empty; its head is on D_pop slice i
//   D_pop    in   [drvrs*pckg_sz]  FIFO head data, slice i = [i*pckg_sz +: pckg_sz]
//   pop      out  [drvrs]          one-cycle strobe consuming the head of FIFO i
//   push     out  [drvrs]          one-cycle strobe writing D_push slice i into FIFO i
//   D_push   out  [drvrs*pckg_sz]  packet being delivered, same value in every slice
//   pkt_cnt  out  [16]             (ARB_STATS_EN only) delivered packets, saturating
//   drop_cnt out  [16]             (ARB_STATS_EN only) dropped packets, saturating
//
// Build option
//   ARB_STATS_EN : adds the pkt_cnt / drop_cnt statistics outputs.
// -----------------------------------------------------------------------------
module bus_rr_arbiter #(
    parameter int         pckg_sz   = 16,
    parameter int         drvrs     = 4,
    parameter logic [7:0] broadcast = 8'hFF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [drvrs-1:0]         pndng,
    input  logic [drvrs*pckg_sz-1:0] D_pop,
    output logic [drvrs-1:0]         pop,
    output logic [drvrs-1:0]         push,
    output logic [drvrs*pckg_sz-1:0] D_push
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]              pkt_cnt,
    output logic [15:0]              drop_cnt
`endif
);

    localparam int GW = (drvrs > 1) ? $clog2(drvrs) : 1;
    localparam logic [drvrs-1:0] ONE = {{(drvrs-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        POP,
        DELIVER
    } state_t;

    state_t               state;
    logic [GW-1:0]        gnt;
    logic [GW-1:0]        last_gnt;
    logic [pckg_sz-1:0]   pkt;

    logic [GW-1:0]        next_gnt;
    logic [pckg_sz-1:0]   head;
    logic [drvrs-1:0]     head_mask;

    // First requester after 'last', wrapping modulo drvrs; the last-served
    // port is examined last, which gives it the lowest priority.
    function automatic logic [GW-1:0] rr_pick(input logic [drvrs-1:0] req,
                                              input logic [GW-1:0]    last);
        logic [GW-1:0] sel;
        logic          found;
        int            idx;
        sel   = '0;
        found = 1'b0;
        for (int k = 1; k <= drvrs; k++) begin
            idx = (int'(last) + k) % drvrs;
            if (!found && req[idx]) begin
                sel   = GW'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    // Destination set for a packet from 'src'. An all-zero mask means drop.
    function automatic logic [drvrs-1:0] dest_mask(input logic [7:0]    id,
                                                   input logic [GW-1:0] src);
        logic [drvrs-1:0] m;
        if (id == broadcast)
            m = ~(ONE << src);
        else if (int'(id) < drvrs && int'(id) != int'(src))
            m = ONE << id;
        else
            m = '0;
        return m;
    endfunction

`ifdef ARB_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction
`endif

    always_comb begin
        next_gnt  = rr_pick(pndng, last_gnt);
        head      = D_pop[gnt*pckg_sz +: pckg_sz];
        head_mask = dest_mask(head[pckg_sz-1 -: 8], gnt);
    end

    // D_push is a pure fan-out of the packet register; pkt is cleared when
    // DELIVER ends so the bus reads zero outside the delivery cycle.
    assign D_push = {drvrs{pkt}};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            gnt      <= '0;
            last_gnt <= GW'(drvrs - 1);
            pkt      <= '0;
            pop      <= '0;
            push     <= '0;
`ifdef ARB_STATS_EN
            pkt_cnt  <= '0;
            drop_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    push <= '0;
                    pop  <= '0;
                    if (|pndng) begin
                        gnt   <= next_gnt;
                        pop   <= ONE << next_gnt;
                        state <= POP;
                    end
                end
                POP: begin
                    // The FIFO head is still valid on this edge, so the
                    // packet and its delivery mask are captured together.
                    pop   <= '0;
                    pkt   <= head;
                    push  <= head_mask;
                    state <= DELIVER;
                end
                DELIVER: begin
                    push     <= '0;
                    pkt      <= '0;
                    last_gnt <= gnt;
`ifdef ARB_STATS_EN
                    if (push != '0)
                        pkt_cnt  <= sat_inc(pkt_cnt);
                    else
                        drop_cnt <= sat_inc(drop_cnt);
`endif
                    state    <= IDLE;
                end
                default: begin
                    pop   <= '0;
                    push  <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_rr_arbiter
//   Bench for bus_rr_arbiter (drvrs=4, pckg_sz=16). Source FIFOs are modelled
//   as queues; each observed pop produces an expected delivery in a
//   scoreboard that an independent monitor drains against push / D_push.
// -----------------------------------------------------------------------------
module tb_bus_rr_arbiter;

    localparam int N = 4;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   pndng;
    logic [N*W-1:0] D_pop;
    logic [N-1:0]   pop;
    logic [N-1:0]   push;
    logic [N*W-1:0] D_push;
`ifdef ARB_STATS_EN
    logic [15:0]    pkt_cnt;
    logic [15:0]    drop_cnt;
`endif

    bus_rr_arbiter #(.pckg_sz(W), .drvrs(N), .broadcast(8'hFF)) dut (
        .clk      (clk),
        .reset    (reset),
        .pndng    (pndng),
        .D_pop    (D_pop),
        .pop      (pop),
        .push     (push),
        .D_push   (D_push)
`ifdef ARB_STATS_EN
        ,
        .pkt_cnt  (pkt_cnt),
        .drop_cnt (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int           cyc;
        logic [N-1:0] mask;
        logic [W-1:0] pkt;
    } exp_t;

    exp_t         sb[$];
    exp_t         mon_e;
    logic [W-1:0] fifo[N][$];
    int           gnt_log[$];

    int           n_checks = 0;
    int           n_fail   = 0;
    int           cyc      = 0;
    int           last_m   = N - 1;
    int           since    = 3;
    int           defer    = -1;
    int           m_del    = 0;
    int           m_drop   = 0;
    logic [N-1:0] prev_pndng = '0;
    logic         rst_drv  = 1'b0;
    logic         rst_next = 1'b0;
    bit           rand_on  = 1'b0;
    bit           pop_seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Round-robin rule: scan upward from the last served port, wrapping.
    function automatic int rr_pick(input logic [N-1:0] req, input int last);
        for (int k = 1; k <= N; k++)
            if (req[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] dest_mask(input logic [W-1:0] p, input int src);
        int id;
        id = int'(p[W-1 -: 8]);
        if (id == 255) return ~(4'b0001 << src);
        if (id < N && id != src) return 4'b0001 << id;
        return '0;
    endfunction

    task automatic model_reset();
        last_m = N - 1;
        since  = 3;
        defer  = -1;
        m_del  = 0;
        m_drop = 0;
        sb.delete();
    endtask

    // Monitor: every post-edge instant either matches the scoreboard head
    // stamped for this cycle, or must show an idle bus.
    always @(posedge clk) begin
        #1;
        if (reset) begin
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                mon_e = sb.pop_front();
                check("push_mask", 64'(push), 64'(mon_e.mask));
                check("push_data", D_push, {N{mon_e.pkt}});
                if (mon_e.mask != '0) m_del++;
                else                  m_drop++;
            end else begin
                check("push_idle", 64'(push), 64'd0);
                check("dpush_idle", D_push, 64'd0);
            end
        end
    end

    // One cycle: retire the FIFO entry consumed on the last edge, check pop
    // against the timing/priority rules, then drive the next inputs.
    task automatic step();
        int           g;
        int           r;
        logic [7:0]   id;
        logic [N-1:0] m;
        @(negedge clk);
        if (defer >= 0) begin
            void'(fifo[defer].pop_front());
            defer = -1;
        end
        pop_seen = 1'b0;
        check("pop_push_excl", 64'(pop & push), 64'd0);
        if (!rst_drv) begin
            check("rst_pop", 64'(pop), 64'd0);
            check("rst_push", 64'(push), 64'd0);
            check("rst_dpush", D_push, 64'd0);
        end else begin
            if (since < 3) since++;
            if (since >= 3 && prev_pndng != '0) begin
                g = rr_pick(prev_pndng, last_m);
                check("pop_grant", 64'(pop), 64'(4'b0001 << g));
                m = dest_mask(fifo[g][0], g);
                sb.push_back('{cyc + 1, m, fifo[g][0]});
                defer  = g;
                last_m = g;
                since  = 0;
                gnt_log.push_back(g);
                pop_seen = 1'b1;
            end else begin
                check("pop_quiet", 64'(pop), 64'd0);
            end
        end
        if (rand_on) begin
            for (int i = 0; i < N; i++) begin
                if (fifo[i].size() < 4 && $urandom_range(0, 3) == 0) begin
                    r  = $urandom_range(0, 5);
                    id = (r < 4) ? 8'(r) : ((r == 4) ? 8'hFF : 8'($urandom_range(4, 254)));
                    fifo[i].push_back({id, 8'($urandom)});
                end
            end
        end
        if (rst_next != reset) begin
            reset = rst_next;
            if (!rst_next) begin
                model_reset();
                #1;
                check("async_rst_pop", 64'(pop), 64'd0);
                check("async_rst_push", 64'(push), 64'd0);
                check("async_rst_dpush", D_push, 64'd0);
            end
        end
        for (int i = 0; i < N; i++) begin
            pndng[i]          = (fifo[i].size() != 0);
            D_pop[i*W +: W]   = (fifo[i].size() != 0) ? fifo[i][0] : '0;
        end
        prev_pndng = pndng;
        rst_drv    = reset;
    endtask

    task automatic drain();
        int  b;
        bit  busy;
        b = 0;
        do begin
            busy = (sb.size() != 0) || (defer >= 0);
            for (int i = 0; i < N; i++) if (fifo[i].size() != 0) busy = 1'b1;
            if (busy) begin
                step();
                b++;
            end
        end while (busy && b < 300);
        check("drain_timeout", 64'(b >= 300), 64'd0);
        repeat (3) step();
    endtask

    int b6;
    int d0;
    int p0;

    initial begin
        reset = 1'b1;
        pndng = '0;
        D_pop = '0;
        #1 reset = 1'b0;
        rst_next = 1'b0;
        rst_drv  = 1'b0;

        // Reset held with every source pending
        for (int i = 0; i < N; i++) fifo[i].push_back({8'((i + 1) % N), 8'(8'h10 + i)});
        repeat (4) step();
        rst_next = 1'b1;
        gnt_log.delete();
        step();
        drain();
        check("t1_first_gnt", 64'(gnt_log.size() > 0 ? gnt_log[0] : -1), 64'd0);

        // Unicast 1 -> 3, broadcast from 2, two drops from 0
        fifo[1].push_back(16'h03AB);
        drain();
        fifo[2].push_back(16'hFF55);
        drain();
        d0 = m_drop;
        p0 = m_del;
        fifo[0].push_back(16'h0011);
        fifo[0].push_back(16'h0711);
        drain();
`ifdef ARB_STATS_EN
        check("t4_drop_cnt", 64'(drop_cnt), 64'(d0 + 2));
        check("t4_pkt_cnt", 64'(pkt_cnt), 64'(p0));
`endif

        // Fairness: serve port 3 first so the sweep starts at port 0
        fifo[3].push_back(16'h0000);
        drain();
        gnt_log.delete();
        for (int p = 0; p < 3; p++)
            for (int i = 0; i < N; i++) fifo[i].push_back({8'((i + 1) % N), 8'(p)});
        drain();
        for (int k = 0; k < 12; k++)
            check("t5_order", 64'(gnt_log.size() > k ? gnt_log[k] : -1), 64'(k % N));

        // Reset during DELIVER, then restart
        fifo[1].push_back(16'h0200);
        b6 = 0;
        do begin
            step();
            b6++;
        end while (!pop_seen && b6 < 10);
        check("t6_pop_timeout", 64'(pop_seen), 64'd1);
        rst_next = 1'b0;
        step();
        repeat (2) step();
        rst_next = 1'b1;
        gnt_log.delete();
        for (int i = 0; i < N; i++) fifo[i].push_back({8'((i + 2) % N), 8'h5A});
        step();
        drain();
        check("t6_first_gnt", 64'(gnt_log.size() > 0 ? gnt_log[0] : -1), 64'd0);

        // Random traffic
        rand_on = 1'b1;
        repeat (400) step();
        rand_on = 1'b0;
        drain();
        check("sb_empty", 64'(sb.size()), 64'd0);
`ifdef ARB_STATS_EN
        check("final_pkt_cnt", 64'(pkt_cnt), 64'(m_del));
        check("final_drop_cnt", 64'(drop_cnt), 64'(m_drop));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
